processor_z2: RTL and testbench
===============================

# processor_z2

Parametrised second-generation Processor Z core: a 4-stage (Fetch, Decode, Execute, Write-back) in-order pipeline with an internal instruction memory, a NREG x XLEN register file, IRMOV plus four ALU operations, full E/W forwarding, HALT, and illegal-opcode detection. It is the top-level compute block of the Processor Z design. The host loads a program through a load port while idle, then raises `working`. Register contents are exported for observation.

## Interface
- `XLEN`, 32: datapath and register width (at least 16).
- `NREG`, 8: number of architectural registers (at most 15; index 0xF means "none").
- `IMEM_DEPTH`, 512: instruction words; `AW = $clog2(IMEM_DEPTH)`.

- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `load_addr` in AW: instruction memory write address.
- `load_we` in 1: instruction memory write enable; honoured only while `working`=0.
- `load_data` in 32: instruction word.
- `working` in 1: run enable. A low level synchronously clears PC, pipeline valids and `halted`.
- `regs` out NREG*XLEN: flattened register file; r0 is in bits [XLEN-1:0].
- `halted` out 1: HALT has retired.
- `illegal` out 1: sticky; an undefined opcode was decoded.
- `retired` out 16: count of retired valid instructions, including HALT; wraps.

## Operation
- Instruction format: [31:28] icode, [27:24] ifun, [23:20] rA, [19:16] rB, [15:0] valC.
- 0x00 HALT.
- 0x01 NOP.
- 0x10 IRMOV: R[rB] ← zero-extended valC; rA is ignored.
- 0x20 ADD: R[rA] ← R[rA]+R[rB].
- 0x21 SUB: R[rA] ← R[rA]−R[rB].
- 0x22 AND: R[rA] ← R[rA]&R[rB].
- 0x23 XOR: R[rA] ← R[rA]^R[rB].
- All arithmetic is modulo 2^XLEN; there are no flags.
- Any other opcode sets `illegal`, is treated as a NOP, and is not counted in `retired`.
- A destination index ≥ NREG (including 0xF) suppresses the write. A source index ≥ NREG reads 0.
- Fetch: PC drives the synchronous-read memory. PC increments each cycle while running and wraps from IMEM_DEPTH−1 to 0.
- Decode: read operands. Forwarding priority is E result first, then W pending write, then the register file. There are no stalls.
- Execute: ALU or IRMOV select; the result is registered into W.
- Write-back: register file write on the clock edge.
- HALT entering E:
  - PC freezes.
  - The fetch-valid flag clears, so the word read on that edge is discarded.
  - Older instructions drain normally.
- `halted` sets on the edge HALT leaves W. It remains set until `working`=0 or reset.
- When `working`=0: load port writes are accepted and the pipeline is idle. Registers, `illegal` and `retired` hold their values.

## Timing
- Reset values: PC, all pipeline valids, all registers, `halted`, `illegal` and `retired` are 0. Memory contents are not reset.
- `reset_n` assertion takes effect immediately, mid-instruction included.
- Edge 1 is the first rising edge with `working`=1.
  - The instruction at address n updates `regs` on edge 4+n.
  - A HALT at address h asserts `halted` on edge 4+h.
- A back-to-back dependent instruction sees the preceding result through forwarding with zero bubbles.
- Dropping `working` mid-run aborts in-flight instructions on the next edge; those instructions are not retired.
- `load_we` with `working`=1 is ignored.

## Structure
- Package `processor_z_pkg`: opcode constants (HALT, NOP, IRMOV, ADD, SUB, AND, XOR), the `alu_fun_t` enum, field-slice localparams, and the REG_NONE=4'hF constant.
- Sub-module `z_alu`: combinational, XLEN-parametrised, `alu_fun_t` select.
- The instruction memory and register file are inferred inside the core.

## Test plan
- Load 10F00080…10F70087 at addresses 0–7 and 00000000 at address 8, then run.
  - r0..r7 = 0x80..0x87, with r7 written on edge 11.
  - `halted` asserts on edge 12.
  - `retired` = 9.
- Load 10F00005, 10F10003, 21010000, 20000000, HALT.
  - r0 = 4, r1 = 3. This proves forwarding of both the E result and the W result.
- Load 10F200F0, 10F30FF0, 22230000, 23230000, HALT.
  - r2 = 0x0F00, r3 = 0x0FF0.
- Load 70000000 followed by 10F10001 and HALT.
  - `illegal` = 1 and stays set.
  - r1 = 1.
  - `retired` = 2.
- Load 10F90001, 2F010000 and HALT with NREG=8.
  - No register changes.
  - A `load_we` pulse during the run leaves memory unchanged.
- Pulse `reset_n` low on edge 6 of the scenario 1 program.
  - All outputs are 0 immediately.
  - Re-running without reloading the program reproduces the scenario 1 results.

Source files
------------

// File: rtl/processor_z_pkg.sv
// Shared definitions for the Processor Z core: opcodes, ALU select,
// instruction field positions and the "no register" index.
package processor_z_pkg;

  // {icode, ifun} opcode values
  localparam logic [7:0] OP_HALT  = 8'h00;
  localparam logic [7:0] OP_NOP   = 8'h01;
  localparam logic [7:0] OP_IRMOV = 8'h10;
  localparam logic [7:0] OP_ADD   = 8'h20;
  localparam logic [7:0] OP_SUB   = 8'h21;
  localparam logic [7:0] OP_AND   = 8'h22;
  localparam logic [7:0] OP_XOR   = 8'h23;

  // ALU function; encoding equals ifun[1:0] of the ALU opcodes
  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_XOR = 2'd3
  } alu_fun_t;

  // Instruction field slices
  localparam int OP_HI   = 31;
  localparam int OP_LO   = 24;
  localparam int RA_HI   = 23;
  localparam int RA_LO   = 20;
  localparam int RB_HI   = 19;
  localparam int RB_LO   = 16;
  localparam int VALC_HI = 15;
  localparam int VALC_LO = 0;

  localparam logic [3:0] REG_NONE = 4'hF;

endpackage

// File: rtl/z_alu.sv
// Combinational ALU for the Processor Z core; modulo-2^XLEN, no flags.
module z_alu
  import processor_z_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  alu_fun_t          fun,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic [XLEN-1:0]   y
);

  // Select the operation result
  always_comb begin
    y = a + b;
    unique case (fun)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_XOR: y = a ^ b;
      default: y = a + b;
    endcase
  end

endmodule

// File: rtl/processor_z2.sv
// Processor Z second-generation core: F/D/E/W in-order pipeline with
// internal instruction memory, register file, E/W forwarding and HALT.
module processor_z2
  import processor_z_pkg::*;
#(
  parameter  int XLEN       = 32,
  parameter  int NREG       = 8,
  parameter  int IMEM_DEPTH = 512,
  localparam int AW         = $clog2(IMEM_DEPTH)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [AW-1:0]        load_addr,
  input  logic                 load_we,
  input  logic [31:0]          load_data,
  input  logic                 working,
  output logic [NREG*XLEN-1:0] regs,
  output logic                 halted,
  output logic                 illegal,
  output logic [15:0]          retired
);

  logic [31:0]     imem [IMEM_DEPTH];

  logic [AW-1:0]   pc_q, pc_d;
  logic            f_vld_q, f_vld_d;
  logic [31:0]     f_word_q;
  logic            halting_q, halting_d;
  logic            halt_stop;

  logic            e_vld_q, e_vld_d;
  logic            e_we_q, e_we_d;
  logic            e_halt_q, e_halt_d;
  logic            e_irmov_q, e_irmov_d;
  logic [3:0]      e_dst_q, e_dst_d;
  alu_fun_t        e_fun_q, e_fun_d;
  logic [XLEN-1:0] e_a_q, e_a_d, e_b_q, e_b_d;
  logic [XLEN-1:0] alu_y, e_result;

  logic            w_vld_q, w_vld_d;
  logic            w_we_q, w_we_d;
  logic            w_halt_q, w_halt_d;
  logic [3:0]      w_dst_q, w_dst_d;
  logic [XLEN-1:0] w_val_q, w_val_d;

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic            halted_q, halted_d;
  logic            illegal_q, illegal_d;
  logic [15:0]     retired_q, retired_d;

  logic [7:0]      dec_op;
  logic [3:0]      dec_ra, dec_rb;
  logic [15:0]     dec_valc;
  logic            dec_legal, dec_halt, dec_irmov, dec_alu;
  logic [XLEN-1:0] rf_a, rf_b, op_a, op_b;

  // Out-of-range sources read 0; otherwise E result beats W pending write beats RF
  function automatic logic [XLEN-1:0] fwd_operand(
    input logic [3:0]      idx,
    input logic [XLEN-1:0] rf_val,
    input logic            e_hit_en,
    input logic [3:0]      e_dst,
    input logic [XLEN-1:0] e_val,
    input logic            w_hit_en,
    input logic [3:0]      w_dst,
    input logic [XLEN-1:0] w_val
  );
    logic [XLEN-1:0] res;
    if (idx >= 4'(NREG))                res = '0;
    else if (e_hit_en && e_dst == idx)  res = e_val;
    else if (w_hit_en && w_dst == idx)  res = w_val;
    else                                res = rf_val;
    return res;
  endfunction

  // Instruction memory: host load port (idle only) and synchronous fetch read
  always_ff @(posedge clock) begin
    if (load_we && !working) imem[load_addr] <= load_data;
    f_word_q <= imem[pc_q];
  end

  // Decode the fetched word and read forwarded operands
  always_comb begin
    dec_op    = f_word_q[OP_HI:OP_LO];
    dec_ra    = f_word_q[RA_HI:RA_LO];
    dec_rb    = f_word_q[RB_HI:RB_LO];
    dec_valc  = f_word_q[VALC_HI:VALC_LO];
    dec_halt  = (dec_op == OP_HALT);
    dec_irmov = (dec_op == OP_IRMOV);
    dec_alu   = (dec_op == OP_ADD) || (dec_op == OP_SUB) ||
                (dec_op == OP_AND) || (dec_op == OP_XOR);
    dec_legal = dec_halt || (dec_op == OP_NOP) || dec_irmov || dec_alu;
    rf_a = '0;
    rf_b = '0;
    for (int i = 0; i < NREG; i++) begin
      if (dec_ra == 4'(i)) rf_a = regs_q[i];
      if (dec_rb == 4'(i)) rf_b = regs_q[i];
    end
    op_a = fwd_operand(dec_ra, rf_a, e_vld_q && e_we_q, e_dst_q, e_result,
                       w_vld_q && w_we_q, w_dst_q, w_val_q);
    op_b = fwd_operand(dec_rb, rf_b, e_vld_q && e_we_q, e_dst_q, e_result,
                       w_vld_q && w_we_q, w_dst_q, w_val_q);
  end

  z_alu #(.XLEN(XLEN)) u_alu (
    .fun (e_fun_q),
    .a   (e_a_q),
    .b   (e_b_q),
    .y   (alu_y)
  );

  // Execute result: IRMOV carries its zero-extended constant in operand B
  always_comb begin
    e_result = e_irmov_q ? e_b_q : alu_y;
  end

  // Next-state for PC, stage valids, stage data, register file and status
  always_comb begin
    pc_d        = pc_q;
    f_vld_d     = 1'b0;
    halting_d   = halting_q;
    halt_stop   = 1'b0;
    e_vld_d     = 1'b0;
    w_vld_d     = 1'b0;
    halted_d    = halted_q;
    illegal_d   = illegal_q;
    retired_d   = retired_q;
    regs_d      = regs_q;
    e_we_d      = dec_irmov || dec_alu;
    e_dst_d     = dec_irmov ? dec_rb : dec_ra;
    e_halt_d    = dec_halt;
    e_irmov_d   = dec_irmov;
    e_fun_d     = alu_fun_t'(dec_op[1:0]);
    e_a_d       = op_a;
    e_b_d       = dec_irmov ? XLEN'(dec_valc) : op_b;
    w_we_d      = e_we_q;
    w_dst_d     = e_dst_q;
    w_halt_d    = e_halt_q;
    w_val_d     = e_result;
    if (!working) begin
      pc_d      = '0;
      halting_d = 1'b0;
      halted_d  = 1'b0;
    end else begin
      // HALT entering E freezes PC and discards the word fetched on that edge
      halt_stop = halting_q || (f_vld_q && dec_halt);
      halting_d = halt_stop;
      f_vld_d   = !halt_stop;
      if (!halt_stop) pc_d = (pc_q == AW'(IMEM_DEPTH - 1)) ? '0 : pc_q + 1'b1;
      e_vld_d   = f_vld_q && dec_legal;
      illegal_d = illegal_q || (f_vld_q && !dec_legal);
      w_vld_d   = e_vld_q;
      if (w_vld_q) begin
        retired_d = retired_q + 16'd1;
        if (w_halt_q) halted_d = 1'b1;
        if (w_we_q) begin
          for (int i = 0; i < NREG; i++) begin
            if (w_dst_q == 4'(i)) regs_d[i] = w_val_q;
          end
        end
      end
    end
  end

  // Control state and architectural registers (asynchronous reset)
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q      <= '0;
      f_vld_q   <= 1'b0;
      halting_q <= 1'b0;
      e_vld_q   <= 1'b0;
      w_vld_q   <= 1'b0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      retired_q <= '0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      pc_q      <= pc_d;
      f_vld_q   <= f_vld_d;
      halting_q <= halting_d;
      e_vld_q   <= e_vld_d;
      w_vld_q   <= w_vld_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
      regs_q    <= regs_d;
    end
  end

  // Pipeline data registers; qualified by the valids so no reset needed
  always_ff @(posedge clock) begin
    e_we_q    <= e_we_d;
    e_dst_q   <= e_dst_d;
    e_halt_q  <= e_halt_d;
    e_irmov_q <= e_irmov_d;
    e_fun_q   <= e_fun_d;
    e_a_q     <= e_a_d;
    e_b_q     <= e_b_d;
    w_we_q    <= w_we_d;
    w_dst_q   <= w_dst_d;
    w_halt_q  <= w_halt_d;
    w_val_q   <= w_val_d;
  end

  for (genvar gi = 0; gi < NREG; gi++) begin : g_regs
    assign regs[gi*XLEN +: XLEN] = regs_q[gi];
  end

  assign halted  = halted_q;
  assign illegal = illegal_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_processor_z2.sv
// Self-checking bench for processor_z2: directed programs plus random
// programs compared edge by edge against an instruction-level model.
module tb_processor_z2;

  localparam int XLEN = 32;
  localparam int NREG = 8;
  localparam int DEPTH = 512;
  localparam int AW = 9;
  localparam int RW = NREG * XLEN;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          working;
  logic          load_we;
  logic [AW-1:0] load_addr;
  logic [31:0]   load_data;
  logic [RW-1:0] regs;
  logic          halted;
  logic          illegal;
  logic [15:0]   retired;

  always #5 clock = ~clock;

  processor_z2 #(.XLEN(XLEN), .NREG(NREG), .IMEM_DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .load_addr (load_addr),
    .load_we   (load_we),
    .load_data (load_data),
    .working   (working),
    .regs      (regs),
    .halted    (halted),
    .illegal   (illegal),
    .retired   (retired)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Architectural model state carried across runs
  logic [RW-1:0] m_regs;
  logic          m_ill;
  logic [15:0]   m_ret;

  logic [31:0]   prog[$];
  logic [RW-1:0] snap[64];
  bit            snap_ill[64];
  int            h;

  // Execute the program sequentially from address 0 up to its HALT
  task automatic build_model();
    logic [RW-1:0]   r;
    logic [31:0]     w;
    logic [7:0]      op;
    int              ra, rb;
    logic [XLEN-1:0] a, b;
    r = m_regs;
    h = -1;
    for (int n = 0; n < prog.size() && n < 64; n++) begin
      w  = prog[n];
      op = w[31:24];
      ra = int'(w[23:20]);
      rb = int'(w[19:16]);
      a  = (ra < NREG) ? r[ra*XLEN +: XLEN] : '0;
      b  = (rb < NREG) ? r[rb*XLEN +: XLEN] : '0;
      snap_ill[n] = 1'b0;
      case (op)
        8'h00, 8'h01: ;
        8'h10: if (rb < NREG) r[rb*XLEN +: XLEN] = {16'h0, w[15:0]};
        8'h20: if (ra < NREG) r[ra*XLEN +: XLEN] = a + b;
        8'h21: if (ra < NREG) r[ra*XLEN +: XLEN] = a - b;
        8'h22: if (ra < NREG) r[ra*XLEN +: XLEN] = a & b;
        8'h23: if (ra < NREG) r[ra*XLEN +: XLEN] = a ^ b;
        default: snap_ill[n] = 1'b1;
      endcase
      snap[n] = r;
      if (op == 8'h00) begin
        h = n;
        break;
      end
    end
    if (h < 0) begin
      $display("FAIL model program has no HALT");
      $fatal(1);
    end
  endtask

  // Expected outputs just after edge e of a run
  task automatic expect_at(input int e, output logic [RW-1:0] xr, output logic [15:0] xret,
                           output logic xill, output logic xhalt);
    int k, ki;
    k = e - 4;
    if (k > h) k = h;
    xr = (k < 0) ? m_regs : snap[k];
    xret = m_ret;
    for (int j = 0; j <= k; j++) if (!snap_ill[j]) xret = xret + 16'd1;
    ki = e - 2;
    if (ki > h) ki = h;
    xill = m_ill;
    for (int j = 0; j <= ki; j++) if (snap_ill[j]) xill = 1'b1;
    xhalt = (e >= 4 + h);
  endtask

  task automatic load_prog();
    for (int i = 0; i < prog.size(); i++) begin
      load_addr = AW'(i);
      load_data = prog[i];
      load_we   = 1'b1;
      @(posedge clock); #1;
    end
    load_we = 1'b0;
  endtask

  task automatic check_all(input string tag, input logic [RW-1:0] xr, input logic [15:0] xret,
                           input logic xill, input logic xhalt);
    check_val({tag, " regs"}, regs, xr);
    check_val({tag, " retired"}, RW'(retired), RW'(xret));
    check_val({tag, " illegal"}, RW'(illegal), RW'(xill));
    check_val({tag, " halted"}, RW'(halted), RW'(xhalt));
  endtask

  // Run the loaded program; optionally stop early by dropping working or by reset
  task automatic run_prog(input string name, input int stop_at, input bit do_reset, input bit poke);
    logic [RW-1:0] xr;
    logic [15:0]   xret;
    logic          xill, xhalt;
    int            last;
    build_model();
    last = h + 6;
    if (stop_at > 0 && stop_at < last) last = stop_at;
    working = 1'b1;
    for (int e = 1; e <= last; e++) begin
      @(posedge clock); #1;
      expect_at(e, xr, xret, xill, xhalt);
      check_all($sformatf("%s e%0d", name, e), xr, xret, xill, xhalt);
      if (poke && e == 2) begin
        load_we   = 1'b1;
        load_addr = AW'(1);
        load_data = 32'h10F00077;
      end else if (poke && e == 3) begin
        load_we = 1'b0;
      end
    end
    if (do_reset) begin
      reset_n = 1'b0;
      working = 1'b0;
      #1;
      check_all({name, " async reset"}, '0, 16'd0, 1'b0, 1'b0);
      m_regs = '0;
      m_ret  = '0;
      m_ill  = 1'b0;
      @(posedge clock); #1;
      reset_n = 1'b1;
    end else begin
      working = 1'b0;
      m_regs = xr;
      m_ret  = xret;
      m_ill  = xill;
      for (int i = 0; i < 2; i++) begin
        @(posedge clock); #1;
        check_all($sformatf("%s idle%0d", name, i), m_regs, m_ret, m_ill, 1'b0);
      end
    end
  endtask

  function automatic logic [31:0] rand_instr();
    int          kind;
    logic [3:0]  ra, rb;
    logic [31:0] w;
    kind = $urandom_range(0, 9);
    ra = 4'($urandom_range(0, 9));
    rb = 4'($urandom_range(0, 9));
    if ($urandom_range(0, 15) == 0) ra = 4'hF;
    case (kind)
      0, 1, 2, 3: w = {8'h10, 4'($urandom), rb, 16'($urandom)};
      4, 5, 6, 7: w = {4'h2, 2'b00, 2'($urandom), ra, rb, 16'($urandom)};
      8:          w = {8'h01, 24'($urandom)};
      default: begin
        case ($urandom_range(0, 3))
          0:       w = {8'h02, 24'($urandom)};
          1:       w = {8'h11, 24'($urandom)};
          2:       w = {8'h24, 24'($urandom)};
          default: w = {4'($urandom_range(3, 15)), 28'($urandom)};
        endcase
      end
    endcase
    return w;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    reset_n   = 1'b0;
    working   = 1'b0;
    load_we   = 1'b0;
    load_addr = '0;
    load_data = '0;
    m_regs    = '0;
    m_ret     = '0;
    m_ill     = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_all("reset", '0, 16'd0, 1'b0, 1'b0);
    reset_n = 1'b1;
    @(posedge clock); #1;

    // Eight IRMOVs then HALT
    prog = {32'h10F00080, 32'h10F10081, 32'h10F20082, 32'h10F30083,
            32'h10F40084, 32'h10F50085, 32'h10F60086, 32'h10F70087, 32'h00000000};
    load_prog();
    run_prog("s1", 0, 1'b0, 1'b0);

    // E and W forwarding
    prog = {32'h10F00005, 32'h10F10003, 32'h21010000, 32'h20000000, 32'h00000000};
    load_prog();
    run_prog("s2", 0, 1'b0, 1'b0);

    // AND / XOR
    prog = {32'h10F200F0, 32'h10F30FF0, 32'h22230000, 32'h23230000, 32'h00000000};
    load_prog();
    run_prog("s3", 0, 1'b0, 1'b0);

    // Illegal opcode
    prog = {32'h70000000, 32'h10F10001, 32'h00000000};
    load_prog();
    run_prog("s4", 0, 1'b0, 1'b0);

    // Out-of-range destinations and an ignored load during the run
    prog = {32'h10F90001, 32'h2F010000, 32'h00000000};
    load_prog();
    run_prog("s5a", 0, 1'b0, 1'b1);
    run_prog("s5b", 0, 1'b0, 1'b0);

    // Reset mid-run, then rerun without reloading
    prog = {32'h10F00080, 32'h10F10081, 32'h10F20082, 32'h10F30083,
            32'h10F40084, 32'h10F50085, 32'h10F60086, 32'h10F70087, 32'h00000000};
    load_prog();
    run_prog("s6a", 6, 1'b1, 1'b0);
    run_prog("s6b", 0, 1'b0, 1'b0);

    // Random programs; every fourth one is aborted by dropping working
    for (int t = 0; t < 24; t++) begin
      int len;
      len = $urandom_range(1, 20);
      prog.delete();
      for (int i = 0; i < len; i++) prog.push_back(rand_instr());
      prog.push_back(32'h00000000);
      prog.push_back(rand_instr());
      prog.push_back($urandom);
      load_prog();
      if (t % 4 == 3) run_prog($sformatf("rnd%0d", t), $urandom_range(2, 12), 1'b0, 1'b0);
      else            run_prog($sformatf("rnd%0d", t), 0, 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
